// File: rtl/imem_load_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : imem_load_ctrl
// Purpose  : Sequences a byte-addressed instruction memory. A host streams the
//            program image byte-by-byte, followed by one checksum byte. The
//            controller writes the image and verifies the checksum. It then
//            hands the memory read port to the core fetch path and keeps the
//            core stalled until a verified image is present.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous, active-low reset
//   ld_valid_i     host byte valid
//   ld_byte_i      host byte (program bytes little-endian, then checksum)
//   ld_last_i      current byte is the checksum byte (never written)
//   ld_ready_o     byte accepted when ld_valid_i & ld_ready_o
//   load_req_i     request a reload (honoured in RUN / ERROR)
//   pc_i           core program counter (byte address)
//   mem_addr_o     write pointer while writing, else pc_i[ADDR_W-1:0]
//   mem_we_o       memory byte write strobe
//   mem_wdata_o    memory write byte
//   mem_rdata_i    memory word {b[a+3],b[a+2],b[a+1],b[a]} (combinational)
//   instr_o        instruction presented to the core
//   core_run_o     core enabled
//   fetch_fault_o  current fetch is invalid (RUN only)
//   load_err_o     image rejected
//   prog_len_o     byte length of the verified image
//------------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int          ADDR_W = 8,
  parameter logic [31:0] NOP    = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              load_req_i,
  input  logic [31:0]       pc_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       instr_o,
  output logic              core_run_o,
  output logic              fetch_fault_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   prog_len_o
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  // Write pointer value meaning "memory completely filled".
  localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W:0]   wptr_q,   wptr_d;
  logic [7:0]        sum_q,    sum_d;
  logic [ADDR_W:0]   len_q,    len_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] waddr_q,  waddr_d;
  logic [7:0]        wdata_q,  wdata_d;
  logic              err_q,    err_d;

  logic              w_accept;
  logic              w_check_ok;
  logic [31:0]       w_len_ext;
  logic [31:0]       w_pc_limit;
  logic              w_pc_bad;

  assign w_accept   = ld_valid_i && (state_q == S_LOAD);
  assign w_check_ok = (sum_q == 8'd0) && (wptr_q != '0) && (wptr_q[1:0] == 2'b00);

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (w_accept) begin
          if (ld_last_i) begin
            state_d = S_CHECK;
          end else if (wptr_q == PTR_FULL) begin
            state_d = S_ERROR;
          end
        end
      end
      S_CHECK: begin
        state_d = w_check_ok ? S_RUN : S_ERROR;
      end
      S_RUN: begin
        if (load_req_i) begin
          state_d = S_LOAD;
        end
      end
      default: begin
        if (load_req_i) begin
          state_d = S_LOAD;
        end
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath next-state: write pipeline, pointer, checksum, length, error
  //--------------------------------------------------------------------------
  always_comb begin
    wptr_d  = wptr_q;
    sum_d   = sum_q;
    len_d   = len_q;
    we_d    = 1'b0;   // write strobe lasts exactly one cycle per byte
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_LOAD: begin
        if (w_accept) begin
          if (ld_last_i) begin
            sum_d = sum_q + ld_byte_i;
          end else if (wptr_q != PTR_FULL) begin
            we_d    = 1'b1;
            waddr_d = wptr_q[ADDR_W-1:0];
            wdata_d = ld_byte_i;
            wptr_d  = wptr_q + 1'b1;
            sum_d   = sum_q + ld_byte_i;
          end else begin
            // Overflow: the byte is dropped, no write is issued.
            err_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (w_check_ok) begin
          len_d = wptr_q;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        // RUN or ERROR: a reload request restarts from an empty image.
        if (load_req_i) begin
          wptr_d = '0;
          sum_d  = 8'd0;
          len_d  = '0;
          err_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wptr_q  <= '0;
      sum_q   <= 8'd0;
      len_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  //--------------------------------------------------------------------------
  // Output logic
  //--------------------------------------------------------------------------
  // Fetch is valid only for word-aligned PCs whose whole word lies inside
  // the image. The full 32-bit PC is compared so upper bits cannot alias.
  // prog_len is at least 4 whenever RUN is reached, so no underflow there.
  assign w_len_ext  = {{(31-ADDR_W){1'b0}}, len_q};
  assign w_pc_limit = w_len_ext - 32'd4;
  assign w_pc_bad   = (pc_i[1:0] != 2'b00) || (pc_i > w_pc_limit);

  always_comb begin
    ld_ready_o    = 1'b0;
    core_run_o    = 1'b0;
    fetch_fault_o = 1'b0;
    instr_o       = NOP;
    case (state_q)
      S_LOAD: begin
        ld_ready_o = 1'b1;
      end
      S_RUN: begin
        core_run_o    = 1'b1;
        fetch_fault_o = w_pc_bad;
        instr_o       = w_pc_bad ? NOP : mem_rdata_i;
      end
      default: begin
      end
    endcase
  end

  // A pending write (only possible up to the CHECK cycle) owns the address.
  assign mem_addr_o  = we_q ? waddr_q : pc_i[ADDR_W-1:0];
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign load_err_o  = err_q;
  assign prog_len_o  = len_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_imem_load_ctrl
// Purpose  : Directed self-checking bench for imem_load_ctrl. Two instances:
//            ADDR_W=8 for the main flows and ADDR_W=4 for overflow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_imem_load_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- ADDR_W = 8 instance ----------------
  logic        rst, ld_valid, ld_last, ld_ready, load_req;
  logic [7:0]  ld_byte;
  logic [31:0] pc;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata, instr;
  logic        core_run, fetch_fault, load_err;
  logic [8:0]  prog_len;
  logic [7:0]  mem8 [256];

  imem_load_ctrl #(.ADDR_W(8), .NOP(NOP)) u_dut8 (
    .clk_i(clk), .reset_i(rst), .ld_valid_i(ld_valid), .ld_byte_i(ld_byte),
    .ld_last_i(ld_last), .ld_ready_o(ld_ready), .load_req_i(load_req), .pc_i(pc),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .instr_o(instr), .core_run_o(core_run),
    .fetch_fault_o(fetch_fault), .load_err_o(load_err), .prog_len_o(prog_len)
  );

  always @(posedge clk) if (mem_we) mem8[mem_addr] <= mem_wdata;
  always_comb mem_rdata = {mem8[mem_addr + 8'd3], mem8[mem_addr + 8'd2],
                           mem8[mem_addr + 8'd1], mem8[mem_addr]};

  // ---------------- ADDR_W = 4 instance ----------------
  logic        rst4, ld_valid4, ld_last4, ld_ready4, load_req4;
  logic [7:0]  ld_byte4;
  logic [31:0] pc4;
  logic [3:0]  mem_addr4;
  logic        mem_we4;
  logic [7:0]  mem_wdata4;
  logic [31:0] mem_rdata4, instr4;
  logic        core_run4, fetch_fault4, load_err4;
  logic [4:0]  prog_len4;
  logic [7:0]  mem4 [16];

  imem_load_ctrl #(.ADDR_W(4), .NOP(NOP)) u_dut4 (
    .clk_i(clk), .reset_i(rst4), .ld_valid_i(ld_valid4), .ld_byte_i(ld_byte4),
    .ld_last_i(ld_last4), .ld_ready_o(ld_ready4), .load_req_i(load_req4), .pc_i(pc4),
    .mem_addr_o(mem_addr4), .mem_we_o(mem_we4), .mem_wdata_o(mem_wdata4),
    .mem_rdata_i(mem_rdata4), .instr_o(instr4), .core_run_o(core_run4),
    .fetch_fault_o(fetch_fault4), .load_err_o(load_err4), .prog_len_o(prog_len4)
  );

  always @(posedge clk) if (mem_we4) mem4[mem_addr4] <= mem_wdata4;
  always_comb mem_rdata4 = {mem4[mem_addr4 + 4'd3], mem4[mem_addr4 + 4'd2],
                            mem4[mem_addr4 + 4'd1], mem4[mem_addr4]};

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b, input logic last);
    ld_valid4 = 1'b1; ld_byte4 = b; ld_last4 = last;
    tick();
    ld_valid4 = 1'b0; ld_last4 = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
    for (int i = 0; i < 16; i++)  mem4[i] = 8'h00;
    rst = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0; load_req = 1'b0; pc = 32'd0;
    rst4 = 1'b0; ld_valid4 = 1'b0; ld_byte4 = 8'h00; ld_last4 = 1'b0; load_req4 = 1'b0; pc4 = 32'd0;
    tick(); tick();
    rst = 1'b1; rst4 = 1'b1;

    // Reset state
    check("rst_ready",    {31'd0, ld_ready},    32'd1);
    check("rst_core_run", {31'd0, core_run},    32'd0);
    check("rst_load_err", {31'd0, load_err},    32'd0);
    check("rst_mem_we",   {31'd0, mem_we},      32'd0);
    check("rst_prog_len", {23'd0, prog_len},    32'd0);
    check("rst_instr",    instr,                NOP);
    check("rst_fault",    {31'd0, fetch_fault}, 32'd0);

    // 1: 4-byte image, good checksum
    send(8'hB3, 1'b0);
    check("t1_we0",    {31'd0, mem_we},   32'd1);
    check("t1_addr0",  {24'd0, mem_addr}, 32'd0);
    check("t1_wdata0", {24'd0, mem_wdata}, 32'h0000_00B3);
    send(8'h00, 1'b0);
    send(8'h31, 1'b0);
    check("t1_addr2",  {24'd0, mem_addr}, 32'd2);
    check("t1_wdata2", {24'd0, mem_wdata}, 32'h0000_0031);
    send(8'h00, 1'b0);
    check("t1_addr3",  {24'd0, mem_addr}, 32'd3);
    send(8'h1C, 1'b1);
    check("t1_chk_ready", {31'd0, ld_ready}, 32'd0);
    check("t1_chk_we",    {31'd0, mem_we},   32'd0);
    check("t1_chk_run",   {31'd0, core_run}, 32'd0);
    tick();
    check("t1_run",      {31'd0, core_run}, 32'd1);
    check("t1_prog_len", {23'd0, prog_len}, 32'd4);
    check("t1_instr",    instr,             32'h0031_00B3);
    check("t1_fault",    {31'd0, fetch_fault}, 32'd0);
    pc = 32'd4; #1;
    check("t1_pc4_fault", {31'd0, fetch_fault}, 32'd1);
    check("t1_pc4_instr", instr, NOP);
    pc = 32'd0;

    // 2: bad checksum
    pulse_load_req();
    check("t2_reload_run",   {31'd0, core_run}, 32'd0);
    check("t2_reload_ready", {31'd0, ld_ready}, 32'd1);
    check("t2_prog_len_clr", {23'd0, prog_len}, 32'd0);
    send(8'hB3, 1'b0); send(8'h00, 1'b0); send(8'h31, 1'b0); send(8'h00, 1'b0);
    send(8'h1D, 1'b1);
    tick();
    check("t2_load_err", {31'd0, load_err}, 32'd1);
    check("t2_core_run", {31'd0, core_run}, 32'd0);
    check("t2_instr",    instr,             32'h0000_0013);
    check("t2_ready",    {31'd0, ld_ready}, 32'd0);
    load_req = 1'b0; tick();
    check("t2_err_held", {31'd0, load_err}, 32'd1);

    // 3: 6-byte image with correct checksum -> length error
    pulse_load_req();
    check("t3_err_clr", {31'd0, load_err}, 32'd0);
    check("t3_ready",   {31'd0, ld_ready}, 32'd1);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    send(8'hEB, 1'b1);
    tick();
    check("t3_load_err", {31'd0, load_err}, 32'd1);
    check("t3_core_run", {31'd0, core_run}, 32'd0);

    // 4: 8-byte image, fetch bounds
    pulse_load_req();
    send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b0);
    send(8'h93, 1'b0); send(8'h05, 1'b0); send(8'h20, 1'b0); send(8'h00, 1'b0);
    send(8'h20, 1'b1);
    pc = 32'd2;
    tick();
    check("t4_run",       {31'd0, core_run}, 32'd1);
    check("t4_prog_len",  {23'd0, prog_len}, 32'd8);
    check("t4_pc2_fault", {31'd0, fetch_fault}, 32'd1);
    check("t4_pc2_instr", instr, NOP);
    pc = 32'd8; #1;
    check("t4_pc8_fault", {31'd0, fetch_fault}, 32'd1);
    check("t4_pc8_instr", instr, NOP);
    pc = 32'd4; #1;
    check("t4_pc4_fault", {31'd0, fetch_fault}, 32'd0);
    check("t4_pc4_addr",  {24'd0, mem_addr}, 32'd4);
    check("t4_pc4_instr", instr, 32'h0020_0593);
    pc = 32'd0; #1;
    check("t4_pc0_instr", instr, 32'h0010_0513);
    pc = 32'h0000_0100; #1;
    check("t4_pcup_fault", {31'd0, fetch_fault}, 32'd1);
    check("t4_pcup_instr", instr, NOP);
    pc = 32'd0;

    // 6: reset mid-load, full reload, then load_req in RUN
    pulse_load_req();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    rst = 1'b0; tick(); rst = 1'b1;
    check("t6_rst_ready",    {31'd0, ld_ready}, 32'd1);
    check("t6_rst_we",       {31'd0, mem_we},   32'd0);
    check("t6_rst_prog_len", {23'd0, prog_len}, 32'd0);
    send(8'hB3, 1'b0);
    check("t6_addr0", {24'd0, mem_addr}, 32'd0);
    send(8'h00, 1'b0); send(8'h31, 1'b0); send(8'h00, 1'b0);
    send(8'h1C, 1'b1);
    tick();
    check("t6_run",      {31'd0, core_run}, 32'd1);
    check("t6_prog_len", {23'd0, prog_len}, 32'd4);
    check("t6_instr",    instr, 32'h0031_00B3);
    pulse_load_req();
    check("t6_req_run",   {31'd0, core_run}, 32'd0);
    check("t6_req_ready", {31'd0, ld_ready}, 32'd1);

    // 5: ADDR_W=4 overflow on the 17th non-last byte
    for (int i = 0; i < 16; i++) send4(8'(i + 1), 1'b0);
    check("t5_addr15",  {28'd0, mem_addr4}, 32'd15);
    check("t5_ready16", {31'd0, ld_ready4}, 32'd1);
    send4(8'hAA, 1'b0);
    check("t5_ovf_err", {31'd0, load_err4}, 32'd1);
    check("t5_ovf_we",  {31'd0, mem_we4},   32'd0);
    check("t5_ovf_run", {31'd0, core_run4}, 32'd0);
    tick();
    check("t5_mem0", {24'd0, mem4[0]}, 32'h0000_0001);
    check("t5_mem15", {24'd0, mem4[15]}, 32'h0000_0010);
    check("t5_instr", instr4, NOP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
